// File: rtl/tff_pkg.sv
// Shared types and defaults for the stepped T flip-flop counter.
//   mode_e                  : per-step update mode (HOLD/UP/DOWN/TOGGLE)
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms of stable level at 50 MHz
package tff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce filter and
// press (0->1) detector.
//   CLK50M  : board clock
//   RST     : asynchronous active-high reset
//   A_noisy : raw asynchronous button level
//   step    : one-cycle pulse per debounced press
module btn_conditioner
  import tff_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic CLK50M,
  input  logic RST,
  input  logic A_noisy,
  output logic step
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic             r_step;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_accept;

  // The count only advances while the synchronised level disagrees with
  // the accepted level; any agreement restarts the interval.
  assign w_differs = (r_sync != r_stable);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_step   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= A_noisy;
      r_sync <= r_meta;
      // Step is registered alongside the stable update, so it fires on
      // the same edge stable rises and never on a release.
      r_step <= w_accept && r_sync;
      if (w_accept) begin
        r_stable <= r_sync;
      end
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign step = r_step;

endmodule

// File: rtl/tff_step_counter.sv
// Multi-bit debounced step register: each clean button press holds,
// increments, decrements or toggles Q according to mode; load overrides.
//   CLK50M : board clock          RST  : async active-high reset
//   button : raw step button      mode : update mode (mode_e)
//   T      : toggle mask          load : synchronous parallel load
//   D      : load value           Q    : register value
//   notQ   : ~Q (combinational)   wrap : one-cycle UP/DOWN wrap pulse
module tff_step_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             CLK50M,
  input  logic             RST,
  input  logic             button,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] T,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             wrap
);

  logic             w_step;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             r_wrap;
  logic             w_wrap_next;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .CLK50M (CLK50M),
    .RST    (RST),
    .A_noisy(button),
    .step   (w_step)
  );

  // load wins over a coincident step; that step is simply dropped.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (load) begin
      w_q_next = D;
    end else if (w_step) begin
      case (mode)
        MODE_UP: begin
          w_q_next    = r_q + WIDTH'(1);
          w_wrap_next = &r_q;
        end
        MODE_DOWN: begin
          w_q_next    = r_q - WIDTH'(1);
          w_wrap_next = ~|r_q;
        end
        MODE_TOGGLE: w_q_next = r_q ^ T;
        default:     w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign Q    = r_q;
  assign notQ = ~r_q;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_tff_step_counter.sv
// Bench for tff_step_counter: a WIDTH=4 and a WIDTH=1 instance, both with
// DEBOUNCE_CYCLES=4, checked every cycle against a window-based model.
module tb_tff_step_counter;
  import tff_pkg::*;

  localparam int DC = 4;

  logic CLK50M = 1'b0;
  logic RST    = 1'b1;
  always #5 CLK50M = ~CLK50M;

  logic       btn4 = 1'b0, ld4 = 1'b0;
  mode_e      mode4 = MODE_HOLD;
  logic [3:0] t4 = '0, d4 = '0, q4, nq4;
  logic       wrap4;

  logic       btn1 = 1'b0, ld1 = 1'b0;
  mode_e      mode1 = MODE_HOLD;
  logic [0:0] t1 = '0, d1 = '0, q1, nq1;
  logic       wrap1;

  tff_step_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(DC)) u4 (
    .CLK50M(CLK50M), .RST(RST), .button(btn4), .mode(mode4), .T(t4),
    .load(ld4), .D(d4), .Q(q4), .notQ(nq4), .wrap(wrap4)
  );

  tff_step_counter #(.WIDTH(1), .DEBOUNCE_CYCLES(DC)) u1 (
    .CLK50M(CLK50M), .RST(RST), .button(btn1), .mode(mode1), .T(t1),
    .load(ld1), .D(d1), .Q(q1), .notQ(nq1), .wrap(wrap1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: stable flips once the last DC synchronised samples (taken since
  // reset or the previous flip) all disagree with it.
  bit        m_s1[2], m_s2[2], m_st[2], m_step[2], m_wrap[2];
  int        m_q[2], m_hlen[2];
  bit [15:0] m_win[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
      m_q[i] = 0; m_hlen[i] = 0; m_win[i] = '0;
    end
  endtask

  task automatic model_edge(input int i, input int w, input bit btn,
                            input int md, input int t, input bit ld, input int d);
    int        mask;
    bit [15:0] win;
    bit        flip;
    mask = (1 << w) - 1;
    win  = {m_win[i][14:0], m_s2[i]};
    if (m_hlen[i] < DC) m_hlen[i]++;
    flip = (m_hlen[i] >= DC) &&
           (m_st[i] ? (win[DC-1:0] == '0) : (win[DC-1:0] == '1));
    m_wrap[i] = 0;
    if (ld) begin
      m_q[i] = d & mask;
    end else if (m_step[i]) begin
      case (md)
        1: begin m_wrap[i] = (m_q[i] == mask); m_q[i] = (m_q[i] + 1) % (mask + 1); end
        2: begin m_wrap[i] = (m_q[i] == 0);    m_q[i] = (m_q[i] + mask) % (mask + 1); end
        3: m_q[i] = m_q[i] ^ (t & mask);
        default: ;
      endcase
    end
    m_step[i] = flip && !m_st[i];
    if (flip) begin
      m_st[i]   = m_s2[i];
      m_hlen[i] = 0;
    end
    m_win[i] = win;
    m_s2[i]  = m_s1[i];
    m_s1[i]  = btn;
  endtask

  initial forever begin
    @(posedge CLK50M or posedge RST);
    if (RST) model_reset();
    else begin
      model_edge(0, 4, btn4, int'(mode4), int'(t4), ld4, int'(d4));
      model_edge(1, 1, btn1, int'(mode1), int'(t1), ld1, int'(d1));
    end
  end

  always @(negedge CLK50M) begin
    chk("q4",    int'(q4),    m_q[0]);
    chk("notq4", int'(nq4),   15 - m_q[0]);
    chk("wrap4", int'(wrap4), int'(m_wrap[0]));
    chk("q1",    int'(q1),    m_q[1]);
    chk("notq1", int'(nq1),   1 - m_q[1]);
    chk("wrap1", int'(wrap1), int'(m_wrap[1]));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK50M);
  endtask

  task automatic load4(input logic [3:0] v);
    ld4 = 1'b1; d4 = v;
    cyc(1);
    ld4 = 1'b0;
  endtask

  int run4 = 0, run1 = 0;

  initial begin
    cyc(3);
    chk("rst_q", int'(q4), 0);
    chk("rst_notq", int'(nq4), 4'hF);
    chk("rst_wrap", int'(wrap4), 0);
    RST = 1'b0;
    cyc(2);

    load4(4'hE);
    chk("load_e", int'(q4), 4'hE);

    // UP press held 10 cycles: Q changes at edge DC+3 = 7
    mode4 = MODE_UP; btn4 = 1'b1;
    cyc(6); chk("up_before_e7", int'(q4), 4'hE);
    cyc(1); chk("up_e7", int'(q4), 4'hF); chk("up_e7_wrap", int'(wrap4), 0);
    cyc(3); btn4 = 1'b0; cyc(10);
    btn4 = 1'b1;
    cyc(7); chk("up_wrap_q", int'(q4), 0); chk("up_wrap_pulse", int'(wrap4), 1);
    cyc(1); chk("up_wrap_end", int'(wrap4), 0);
    cyc(10); chk("up_held", int'(q4), 0);
    btn4 = 1'b0; cyc(10);

    // glitches shorter than DC synchronised cycles
    btn4 = 1'b1; cyc(3); btn4 = 1'b0; cyc(2);
    btn4 = 1'b1; cyc(3); btn4 = 1'b0; cyc(10);
    chk("glitch", int'(q4), 0);
    btn4 = 1'b1; cyc(10); chk("long_press", int'(q4), 1);
    btn4 = 1'b0; cyc(10); chk("one_step", int'(q4), 1);

    mode4 = MODE_DOWN; load4(4'h0);
    btn4 = 1'b1;
    cyc(7); chk("down_q", int'(q4), 4'hF); chk("down_wrap", int'(wrap4), 1);
    cyc(1); chk("down_wrap_end", int'(wrap4), 0);
    cyc(2); btn4 = 1'b0; cyc(10);

    mode4 = MODE_TOGGLE; t4 = 4'b1010; load4(4'b0110);
    btn4 = 1'b1;
    cyc(7); chk("toggle_q", int'(q4), 4'b1100); chk("toggle_wrap", int'(wrap4), 0);
    cyc(3); btn4 = 1'b0; cyc(10);

    // load coincides with the step pulse
    mode4 = MODE_UP; btn4 = 1'b1;
    cyc(6); ld4 = 1'b1; d4 = 4'h5;
    cyc(1); ld4 = 1'b0;
    chk("prio_q", int'(q4), 5); chk("prio_wrap", int'(wrap4), 0);
    cyc(5); chk("prio_no_inc", int'(q4), 5);
    btn4 = 1'b0; cyc(10);

    // async reset mid-press, button held across release
    load4(4'h9); chk("pre_rst", int'(q4), 9);
    btn4 = 1'b1; cyc(3);
    #2 RST = 1'b1;
    #1 chk("arst_q", int'(q4), 0); chk("arst_notq", int'(nq4), 4'hF);
    chk("arst_wrap", int'(wrap4), 0);
    @(negedge CLK50M); RST = 1'b0;
    cyc(6); chk("held_rst_wait", int'(q4), 0);
    cyc(1); chk("held_rst_step", int'(q4), 1);
    cyc(3); btn4 = 1'b0; cyc(10);

    // WIDTH=1 toggle: 1,0,1,0
    mode1 = MODE_TOGGLE; t1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      btn1 = 1'b1; cyc(7);
      chk("w1_toggle", int'(q1), (k % 2 == 0) ? 1 : 0);
      chk("w1_notq", int'(nq1), (k % 2 == 0) ? 0 : 1);
      cyc(3); btn1 = 1'b0; cyc(10);
    end

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK50M);
      if (run4 == 0) begin btn4 = 1'($urandom); run4 = $urandom_range(1, 9); end
      else run4--;
      if (run1 == 0) begin btn1 = 1'($urandom); run1 = $urandom_range(1, 9); end
      else run1--;
      mode4 = mode_e'($urandom_range(0, 3));
      mode1 = mode_e'($urandom_range(0, 3));
      t4 = 4'($urandom); d4 = 4'($urandom); ld4 = ($urandom_range(0, 15) == 0);
      t1 = 1'($urandom); d1 = 1'($urandom); ld1 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 RST = 1'b1;
        #5 RST = 1'b0;
      end
    end
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tff_step_counter.md
# tff_step_counter

Parametrised multi-bit successor to the single-bit debounced T flip-flop used in the lab board designs. A push-button step input is synchronised, debounced and edge-detected internally. Each clean press then updates a WIDTH-bit register in one of four modes: hold, count up, count down or per-bit toggle. The block also provides synchronous parallel load and a wrap indication. It sits between board push-buttons/switches and LED/7-segment display logic, on the 50 MHz board clock.

## Interface

**Parameters**
- WIDTH, 4: register width in bits, ≥1.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level (10 ms at 50 MHz), ≥2.

**Ports**
- CLK50M  input  1  board clock. One clock; all state is on its rising edge.
- RST  input  1  reset, asynchronous and active-high.
- button  input  1  raw, noisy, asynchronous step push-button.
- mode  input  2  tff_pkg::mode_e. HOLD=00, UP=01, DOWN=10, TOGGLE=11. Sampled on the step cycle.
- T  input  WIDTH  toggle mask used in TOGGLE mode.
- load  input  1  synchronous parallel load. Level input, already synchronous, not debounced.
- D  input  WIDTH  load value.
- Q  output  WIDTH  register value.
- notQ  output  WIDTH  always ~Q.
- wrap  output  1  one-cycle pulse when UP or DOWN wraps.

## Operation

- **Conditioner:**
  - button passes through a 2-flop synchroniser to give sync.
  - A counter runs while sync != stable. Each such edge increments it, and when it equals DEBOUNCE_CYCLES-1 then stable <= sync and the count clears.
  - Whenever sync == stable, the count clears. Any glitch therefore restarts the interval.
- **step:** registered one-cycle pulse, asserted on the edge where stable goes 0→1. Releases (1→0) produce no step.
- **Register update priority, per edge:** RST > load > step.
  - load=1: Q <= D and wrap <= 0. A coincident step is discarded, not deferred.
  - step in HOLD: no change.
  - step in UP: Q <= Q+1, modulo 2^WIDTH.
  - step in DOWN: Q <= Q-1, modulo 2^WIDTH.
  - step in TOGGLE: Q <= Q ^ T. With T=0 there is no change.
- **wrap rules:**
  - Pulses for exactly one cycle, with the Q update, for UP from all-ones to 0 and for DOWN from 0 to all-ones.
  - Never pulses in TOGGLE, in HOLD, or on load (including a load of 0).
- **WIDTH=1:** UP, DOWN and TOGGLE with T=1 all invert Q, matching single-bit T flip-flop behaviour. wrap pulses on 1→0 in UP and on 0→1 in DOWN.

## Timing

- **Reset values:** Q=0, notQ=all ones, wrap=0, sync=0, stable=0, debounce count=0, step=0.
- **Reset mid-operation:** any partial debounce interval and any pending step are discarded.
- **Button held high across reset release:** this counts as a new press and produces one step after the full debounce latency.
- **Press latency:** number the first rising edge at which button is sampled high as edge 1.
  - sync=1 after edge 2.
  - stable=1 and step pulse at edge DEBOUNCE_CYCLES+2.
  - Q changes at edge DEBOUNCE_CYCLES+3, provided the button stays high throughout.
- **Glitch rejection:** a pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no step.
- **Press rate:** a press must be followed by a debounced release before the next step. At most one step per press, however long it is held.
- **load latency:** Q reflects D at the first edge where load=1.
- notQ is combinational from Q and has zero latency.

## Structure

- **Package tff_pkg:**
  - typedef enum logic [1:0] mode_e {MODE_HOLD, MODE_UP, MODE_DOWN, MODE_TOGGLE}.
  - localparam DEFAULT_DEBOUNCE_CYCLES = 500000.
- **Sub-module btn_conditioner:**
  - Ports: CLK50M, RST, A_noisy → step.
  - Contents: synchroniser, debounce counter ($clog2(DEBOUNCE_CYCLES) bits) and rise detector.
  - Parametrised by DEBOUNCE_CYCLES. Reusable for other board buttons.
- **Top level:** next-state mux, Q register, wrap register.

## Test plan

DEBOUNCE_CYCLES=4 and WIDTH=4 unless stated.

- Reset: RST pulsed mid-simulation with Q=9 → Q=0, notQ=4'hF and wrap=0 immediately, without waiting for a clock edge.
- UP, clean press held 10 cycles from Q=4'hE:
  - Q=F at edge 7.
  - Second press: Q=0 with a one-cycle wrap pulse.
  - No further change while held.
- Glitch: button high for 3 cycles, low for 2, then high for 3 → no step, Q unchanged. Then high for 10 cycles → exactly one step.
- DOWN from Q=0 → Q=4'hF with wrap=1 for one cycle. TOGGLE with T=4'b1010 from 4'b0110 → 4'b1100, wrap=0.
- Priority: load=1, D=4'h5 on the same edge as the step pulse in UP mode → Q=5, no increment afterwards, wrap=0.
- WIDTH=1, TOGGLE, T=1, four presses → Q sequence 1, 0, 1, 0, with notQ always ~Q.
